blake_msg_loader: RTL

//  Upstream stage of the BLAKE-512 1G-core datapath. Collects a MSG_WORDS x 64-bit message

---
 rtl/blake_msg_loader_pkg.sv | 42 ++++
 rtl/blake_msg_loader_if.sv | 35 +++
 rtl/blake_msg_loader_pad_gen.sv | 29 ++
 rtl/blake_msg_loader.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/blake_msg_loader_pkg.sv
// ============================================================================
//  Module : blake512_pkg
//  Brief  : Shared widths, padding constants, loader state type and padding
//           helper for the BLAKE-512 message loader.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package blake512_pkg;

    localparam int WORD_W    = 64;
    localparam int BLK_W     = 1024;
    localparam int NUM_WORDS = BLK_W / WORD_W;
    localparam int TAIL_W    = 6;
    localparam int TAIL_BASE = NUM_WORDS - TAIL_W;

    localparam logic [WORD_W-1:0] PAD_ONE = 64'h8000_0000_0000_0000;
    localparam logic [WORD_W-1:0] PAD_END = 64'h1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } loader_state_t;

    // Padding content of block word idx when it lies after the last message word.
    function automatic logic [WORD_W-1:0] pad_word(input int idx, input int msg_words);
        logic [WORD_W-1:0] w_val;
        w_val = '0;
        if (idx == msg_words)
            w_val = w_val | PAD_ONE;
        if (idx == NUM_WORDS - 3)
            w_val = w_val | PAD_END;
        if (idx == NUM_WORDS - 1)
            w_val = WORD_W'(msg_words * WORD_W);
        return w_val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/blake_msg_loader_if.sv
// ============================================================================
//  Module : blake_msg_loader_if
//  Brief  : Word stream, core handshake and block bus of the message loader.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface blake_msg_loader_if;
    import blake512_pkg::*;

    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic              abort;
    logic              core_done;
    logic [BLK_W-1:0]  state_buf;
    logic              core_start;
    logic              core_clr;
    logic              busy;
    logic              err_len;

    modport master (
        output s_data, s_valid, s_last, abort, core_done,
        input  s_ready, state_buf, core_start, core_clr, busy, err_len
    );

    modport slave (
        input  s_data, s_valid, s_last, abort, core_done,
        output s_ready, state_buf, core_start, core_clr, busy, err_len
    );

endinterface

`default_nettype wire

// File: rtl/blake_msg_loader_pad_gen.sv
// ============================================================================
//  Module : blake_pad_gen
//  Brief  : Combinational tail of the padded block (words 10..15): the last
//           message word where it falls there, padding after it.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module blake_pad_gen
    import blake512_pkg::*;
#(
    parameter int MSG_WORDS = 10
) (
    input  logic [WORD_W-1:0]             i_last_word,
    input  logic [3:0]                    i_cnt,
    output logic [TAIL_W-1:0][WORD_W-1:0] o_tail_word,
    output logic [TAIL_W-1:0]             o_tail_we
);

    for (genvar gi = 0; gi < TAIL_W; gi++) begin : g_tail
        localparam int c_idx = TAIL_BASE + gi;
        // Words before the last one already hold message data and keep it.
        assign o_tail_word[gi] = (i_cnt == 4'(c_idx)) ? i_last_word : pad_word(c_idx, MSG_WORDS);
        assign o_tail_we[gi]   = (i_cnt <= 4'(c_idx));
    end

endmodule

`default_nettype wire

// File: rtl/blake_msg_loader.sv
// ============================================================================
//  Module : blake_msg_loader
//  Brief  : Collects a MSG_WORDS x 64-bit message, pads it to a 1024-bit
//           BLAKE-512 block, launches the core and holds until core_done.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module blake_msg_loader
    import blake512_pkg::*;
#(
    parameter int MSG_WORDS = 10
) (
    input  logic               clk,
    input  logic               rst,
    blake_msg_loader_if.slave  bus
);

    localparam logic [3:0] c_last_idx = 4'(MSG_WORDS - 1);

    loader_state_t r_state;
    loader_state_t w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;

    logic r_core_start, r_core_clr, r_busy, r_err_len;
    logic w_start_nxt, w_clr_nxt, w_busy_nxt, w_err_nxt;

    logic w_s_ready;
    logic w_beat;
    logic w_clear_words;
    logic w_load_word;
    logic w_load_final;

    logic [TAIL_W-1:0][WORD_W-1:0]    w_tail_word;
    logic [TAIL_W-1:0]                w_tail_we;
    logic [NUM_WORDS-1:0][WORD_W-1:0] w_buf;

    assign w_s_ready = ((r_state == FILL) || (r_state == DRAIN)) && !rst;
    assign w_beat    = bus.s_valid && w_s_ready && !bus.abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FILL;
            r_cnt        <= '0;
            r_core_start <= 1'b0;
            r_core_clr   <= 1'b0;
            r_busy       <= 1'b0;
            r_err_len    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_core_start <= w_start_nxt;
            r_core_clr   <= w_clr_nxt;
            r_busy       <= w_busy_nxt;
            r_err_len    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_start_nxt   = 1'b0;
        w_clr_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_busy_nxt    = r_busy;
        w_clear_words = 1'b0;
        w_load_word   = 1'b0;
        w_load_final  = 1'b0;

        if (bus.abort) begin
            w_state_nxt   = FILL;
            w_cnt_nxt     = '0;
            w_busy_nxt    = 1'b0;
            w_clr_nxt     = 1'b1;
            w_clear_words = 1'b1;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_beat) begin
                        if (r_cnt == c_last_idx) begin
                            if (bus.s_last) begin
                                w_load_final = 1'b1;
                                w_start_nxt  = 1'b1;
                                w_state_nxt  = START;
                            end else begin
                                // cnt parks at the last index while the excess drains
                                w_load_word = 1'b1;
                                w_state_nxt = DRAIN;
                            end
                        end else if (bus.s_last) begin
                            w_err_nxt     = 1'b1;
                            w_clear_words = 1'b1;
                            w_cnt_nxt     = '0;
                        end else begin
                            w_load_word = 1'b1;
                            w_cnt_nxt   = r_cnt + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_beat && bus.s_last) begin
                        w_err_nxt     = 1'b1;
                        w_clear_words = 1'b1;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = FILL;
                    end
                end
                START: begin
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = WAIT;
                end
                WAIT: begin
                    if (bus.core_done) begin
                        w_busy_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = FILL;
                    end
                end
                default: w_state_nxt = FILL;
            endcase
        end
    end

    blake_pad_gen #(
        .MSG_WORDS (MSG_WORDS)
    ) u_pad_gen (
        .i_last_word (bus.s_data),
        .i_cnt       (r_cnt),
        .o_tail_word (w_tail_word),
        .o_tail_we   (w_tail_we)
    );

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        logic [WORD_W-1:0] r_word;
        logic [WORD_W-1:0] w_fin_val;
        logic              w_fin_we;

        if (gi >= TAIL_BASE) begin : g_pad_tail
            assign w_fin_val = w_tail_word[gi-TAIL_BASE];
            assign w_fin_we  = w_tail_we[gi-TAIL_BASE];
        end else begin : g_pad_head
            assign w_fin_val = (r_cnt == 4'(gi)) ? bus.s_data : pad_word(gi, MSG_WORDS);
            assign w_fin_we  = (r_cnt <= 4'(gi));
        end

        always_ff @(posedge clk) begin
            if (rst || w_clear_words)
                r_word <= '0;
            else if (w_load_final && w_fin_we)
                r_word <= w_fin_val;
            else if (w_load_word && (r_cnt == 4'(gi)))
                r_word <= bus.s_data;
        end

        assign w_buf[NUM_WORDS-1-gi] = r_word;
    end

    assign bus.s_ready    = w_s_ready;
    assign bus.state_buf  = w_buf;
    assign bus.core_start = r_core_start;
    assign bus.core_clr   = r_core_clr;
    assign bus.busy       = r_busy;
    assign bus.err_len    = r_err_len;

endmodule

`default_nettype wire
